// File: rtl/chorus_delay_ctrl.sv
// Chorus modulated-delay sequencer: writes each accepted sample into the shared
// single-port RAM, then reads two adjacent taps at an LFO-modulated delay.
`timescale 1ns/1ps
module chorus_delay_ctrl #(
   parameter int width_p      = 24,
   parameter int depth_p      = 1024,
   parameter int base_delay_p = 480,
   parameter int mod_depth_p  = 128,
   parameter int frac_w_p     = 8,
   parameter int rate_p       = 64
) (
   input  logic                         clk_i,
   input  logic                         reset_ni,
   input  logic                         valid_i,
   output logic                         ready_o,
   input  logic [width_p-1:0]           data_i,
   output logic                         mem_en_o,
   output logic                         mem_we_o,
   output logic [$clog2(depth_p)-1:0]   mem_addr_o,
   output logic [width_p-1:0]           mem_wdata_o,
   input  logic [width_p-1:0]           mem_rdata_i,
   output logic                         valid_o,
   input  logic                         ready_i,
   output logic [width_p-1:0]           tap0_o,
   output logic [width_p-1:0]           tap1_o,
   output logic [frac_w_p-1:0]          frac_o
);

   localparam int addr_w = $clog2(depth_p);
   localparam int dw     = addr_w + frac_w_p;

   localparam logic [dw:0]     lfo_max  = (dw+1)'(mod_depth_p << frac_w_p);
   localparam logic [dw:0]     rate_w   = (dw+1)'(rate_p);
   localparam logic [dw-1:0]   base_fx  = dw'(base_delay_p << frac_w_p);
   localparam logic [addr_w:0] fill_max = (addr_w+1)'(depth_p);

   typedef enum logic [2:0] {IDLE, WRITE, RD0, RD1, CAP, OUT} state_t;

   state_t              state, state_nxt;
   logic [addr_w-1:0]   wr_ptr, a0, a1, d_int, d_int_now;
   logic [addr_w:0]     fill;
   logic [dw-1:0]       lfo, lfo_nxt, delay;
   logic [dw:0]         lfo_ext, lfo_up;
   logic                lfo_dn, lfo_dn_nxt;
   logic [width_p-1:0]  sample;
   logic [frac_w_p-1:0] frac_q;
   logic                accept, handshake;

   assign delay     = base_fx + lfo;
   assign d_int_now = delay[dw-1:frac_w_p];
   assign accept    = (state == IDLE) && valid_i;
   assign handshake = (state == OUT) && ready_i;

   // Triangle LFO: saturate exactly on the bounds, then turn around.
   always_comb begin
      // NOTE: every always_comb output gets a default first, so no path can infer a latch.
      lfo_nxt    = lfo;
      lfo_dn_nxt = lfo_dn;
      lfo_ext    = {1'b0, lfo};
      lfo_up     = lfo_ext + rate_w;
      if (!lfo_dn) begin
         if (lfo_up >= lfo_max) begin
            lfo_nxt    = lfo_max[dw-1:0];
            lfo_dn_nxt = 1'b1;
         end else begin
            lfo_nxt = lfo_up[dw-1:0];
         end
      end else begin
         if (lfo_ext <= rate_w) begin
            lfo_nxt    = '0;
            lfo_dn_nxt = 1'b0;
         end else begin
            lfo_nxt = lfo - rate_w[dw-1:0];
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      ready_o     = 1'b0;
      valid_o     = 1'b0;
      mem_en_o    = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      unique case (state)
         IDLE: begin
            ready_o = 1'b1;
            if (valid_i) state_nxt = WRITE;
         end
         WRITE: begin
            mem_en_o    = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_ptr;
            mem_wdata_o = sample;
            state_nxt   = RD0;
         end
         RD0: begin
            mem_en_o   = 1'b1;
            mem_addr_o = a0;
            state_nxt  = RD1;
         end
         RD1: begin
            mem_en_o   = 1'b1;
            mem_addr_o = a1;
            state_nxt  = CAP;
         end
         CAP: state_nxt = OUT;
         OUT: begin
            valid_o = 1'b1;
            if (ready_i) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state  <= IDLE;
         wr_ptr <= '0;
         fill   <= '0;
         lfo    <= '0;
         lfo_dn <= 1'b0;
         sample <= '0;
         d_int  <= '0;
         frac_q <= '0;
         a0     <= '0;
         a1     <= '0;
         tap0_o <= '0;
         tap1_o <= '0;
         frac_o <= '0;
      end else begin
         // NOTE: non-blocking assignments keep every register sampling pre-edge values.
         state <= state_nxt;
         if (accept) begin
            sample <= data_i;
            d_int  <= d_int_now;
            frac_q <= delay[frac_w_p-1:0];
            a0     <= wr_ptr - d_int_now;
            a1     <= wr_ptr - d_int_now - 1'b1;
         end
         // Taps older than the written history would expose stale RAM, so they read as 0.
         if (state == RD1)
            tap0_o <= ({1'b0, d_int} > fill) ? '0 : mem_rdata_i;
         if (state == CAP) begin
            tap1_o <= (({1'b0, d_int} + 1'b1) > fill) ? '0 : mem_rdata_i;
            frac_o <= frac_q;
         end
         if (handshake) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != fill_max) fill <= fill + 1'b1;
            lfo    <= lfo_nxt;
            lfo_dn <= lfo_dn_nxt;
         end
      end
   end

endmodule

// File: tb/tb_chorus_delay_ctrl.sv
// Bench for chorus_delay_ctrl: a fixed-delay and a modulated instance, each with
// its own RAM model, checked against a sample-history reference model.
`timescale 1ns/1ps
module tb_chorus_delay_ctrl;

   localparam logic [23:0] ram_key = 24'h5A5A5A;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        valid_i [2];
   logic        ready_o [2];
   logic        ready_i [2];
   logic        valid_o [2];
   logic        mem_en  [2];
   logic        mem_we  [2];
   logic [23:0] data_i  [2];
   logic [23:0] mem_wdata [2];
   logic [23:0] tap0 [2];
   logic [23:0] tap1 [2];
   logic [3:0]  mem_addr [2];
   logic [1:0]  frac [2];

   int total = 0;
   int bad   = 0;
   logic [23:0] hist0 [$];
   logic [23:0] hist1 [$];

   always #5 clk = ~clk;

   // Instance 0: fixed delay; instance 1: mod depth 2 samples, rate 1/4 sample.
   for (genvar g = 0; g < 2; g++) begin : g_dut
      logic [23:0] ram [16];
      logic [23:0] rdata_q;

      chorus_delay_ctrl #(
         .width_p(24), .depth_p(16), .base_delay_p(4),
         .mod_depth_p(2 * g), .frac_w_p(2), .rate_p(1)
      ) u_dut (
         .clk_i(clk), .reset_ni(reset_n),
         .valid_i(valid_i[g]), .ready_o(ready_o[g]), .data_i(data_i[g]),
         .mem_en_o(mem_en[g]), .mem_we_o(mem_we[g]), .mem_addr_o(mem_addr[g]),
         .mem_wdata_o(mem_wdata[g]), .mem_rdata_i(rdata_q),
         .valid_o(valid_o[g]), .ready_i(ready_i[g]),
         .tap0_o(tap0[g]), .tap1_o(tap1[g]), .frac_o(frac[g])
      );

      // Stored scrambled, so never-written words read back as nonzero garbage.
      always @(posedge clk) begin
         if (mem_en[g]) begin
            if (mem_we[g]) ram[mem_addr[g]] <= mem_wdata[g] ^ ram_key;
            rdata_q <= ram[mem_addr[g]] ^ ram_key;
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int hsize(input int i);
      return (i == 0) ? hist0.size() : hist1.size();
   endfunction

   function automatic logic [23:0] hget(input int i, input int k);
      return (i == 0) ? hist0[k] : hist1[k];
   endfunction

   // Triangle position in quarter samples after n completed outputs (peak 8).
   function automatic int tri_pos(input int n);
      int p;
      p = n % 16;
      return (p <= 8) ? p : 16 - p;
   endfunction

   task automatic send(input int i, input logic [23:0] d);
      int w;
      int n;
      w = 0;
      n = hsize(i);
      @(negedge clk);
      while (!ready_o[i] && w < 20) begin
         @(negedge clk);
         w++;
      end
      check("ready_wait", 32'(ready_o[i]), 32'd1);
      valid_i[i] = 1'b1;
      data_i[i]  = d;
      @(posedge clk);
      #1;
      valid_i[i] = 1'b0;
      @(negedge clk);
      check("wr_cmd",  32'({mem_en[i], mem_we[i]}), 32'd3);
      check("wr_addr", 32'(mem_addr[i]), 32'(n % 16));
      check("wr_data", 32'(mem_wdata[i]), 32'(d));
   endtask

   task automatic collect(input int i, input logic [23:0] d, input int hold);
      int n;
      int dq;
      int k;
      int cnt;
      logic [23:0] e0;
      logic [23:0] e1;
      n   = hsize(i);
      dq  = 16 + ((i == 1) ? tri_pos(n) : 0);
      k   = dq / 4;
      e0  = (k <= n) ? hget(i, n - k) : 24'd0;
      e1  = (k + 1 <= n) ? hget(i, n - k - 1) : 24'd0;
      cnt = 1;
      @(posedge clk);
      cnt++;
      @(negedge clk);
      while (!valid_o[i] && cnt < 20) begin
         @(posedge clk);
         cnt++;
         @(negedge clk);
      end
      check("latency", 32'(cnt), 32'd5);
      check("tap0", 32'(tap0[i]), 32'(e0));
      check("tap1", 32'(tap1[i]), 32'(e1));
      check("frac", 32'(frac[i]), 32'(dq % 4));
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         @(negedge clk);
         check("hold_ctl",  32'({valid_o[i], ready_o[i], mem_en[i]}), 32'b100);
         check("hold_tap0", 32'(tap0[i]), 32'(e0));
         check("hold_tap1", 32'(tap1[i]), 32'(e1));
         check("hold_frac", 32'(frac[i]), 32'(dq % 4));
      end
      ready_i[i] = 1'b1;
      @(posedge clk);
      if (i == 0) hist0.push_back(d);
      else        hist1.push_back(d);
      @(negedge clk);
      check("valid_drop", 32'(valid_o[i]), 32'd0);
   endtask

   initial begin
      logic [23:0] d;
      for (int i = 0; i < 2; i++) begin
         valid_i[i] = 1'b0;
         ready_i[i] = 1'b1;
         data_i[i]  = '0;
      end
      reset_n = 1'b0;

      // Reset state on both instances.
      #2;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check("rst_valid", 32'(valid_o[i]), 32'd0);
         check("rst_men",   32'(mem_en[i]),  32'd0);
         check("rst_ready", 32'(ready_o[i]), 32'd1);
         check("rst_taps",  32'({tap0[i], frac[i]}), 32'd0);
         check("rst_tap1",  32'(tap1[i]),    32'd0);
      end
      reset_n = 1'b1;

      // Fixed delay: fill-up masking, ring wrap, and a 10-cycle stall on sample 10.
      for (int s = 1; s <= 40; s++) begin
         d = (s <= 8) ? 24'(s) : (24'($urandom) | 24'd1);
         if (s == 10) ready_i[0] = 1'b0;
         send(0, d);
         collect(0, d, (s == 10) ? 10 : 0);
      end

      // Modulated delay: 2.5 triangle periods of frac/D_int.
      for (int s = 0; s < 40; s++) begin
         d = 24'($urandom) | 24'd1;
         send(1, d);
         collect(1, d, 0);
      end

      // Reset pulse while instance 0 is in RD1.
      send(0, 24'h123456);
      @(posedge clk);
      @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(valid_o[0]), 32'd0);
      check("mid_rst_ready", 32'(ready_o[0]), 32'd1);
      check("mid_rst_men",   32'(mem_en[0]),  32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      hist0.delete();
      hist1.delete();
      send(0, 24'hABCDEF);
      collect(0, 24'hABCDEF, 0);
      d = 24'h00C0DE;
      send(1, d);
      collect(1, d, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
